adc_parallel_driver: RTL and testbench
======================================

Name: adc_parallel_driver

Overview:
Controller for an 8-channel, 16-bit simultaneous-sampling SAR ADC used in hardware mode with a parallel interface (AD7606-class part).
- Periodically pulses the four CONVST lines together.
- Waits for the BUSY handshake to finish.
- Reads all channels with a CS_N/RD_N burst and presents each word on data_out with a one-cycle data_valid strobe.
- Sits between the ADC pins and the downstream sound-localization sample pipeline.

Parameters:
NUM_CHANNELS, 8, words read per conversion (channels A0,A1,B0,B1,C0,C1,D0,D1 in ADC output order)
SAMPLE_PERIOD_CYCLES, 64, clk cycles between conversion starts (must exceed one full convert+read cycle)
CONVST_HIGH_CYCLES, 2, conv_start high pulse width
RD_LOW_CYCLES, 2, read_n low time per word
RD_HIGH_CYCLES, 1, read_n high time between words
BUSY_TIMEOUT_CYCLES, 16, max cycles waiting for busy to rise after CONVST

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
busy  in  1  ADC BUSY; high while converting
data_adc  in  16  ADC parallel data bus DB[15:0]
read_n  out  1  ADC RD_N, active low
write_n  out  1  ADC WR_N; constant 1
chipselect_n  out  1  ADC CS_N, active low
software_mode  out  1  ADC HW_N_SW; constant 0 (hardware mode)
serial_mode  out  1  parallel/serial select; constant 0 (parallel)
standby_n  out  1  ADC STBY_N; constant 1 (active)
conv_start_a  out  1  CONVST A
conv_start_b  out  1  CONVST B
conv_start_c  out  1  CONVST C
conv_start_d  out  1  CONVST D
data_out  out  16  last captured ADC word
data_valid  out  1  one-cycle strobe, data_out is new

Behaviour:
- Clocking: all outputs are registered. Clock is clk only. rst is asynchronous and active-high.
- Reset values:
  - read_n=1, chipselect_n=1, write_n=1.
  - conv_start_a..d=0.
  - data_out=0, data_valid=0.
  - software_mode=0, serial_mode=0, standby_n=1.
  - State=IDLE, period counter=0, word counter=0.
- Reset mid-operation: any assertion of rst returns all outputs to reset values immediately and aborts the burst. No partial data_valid is issued.
- Period counter:
  - Free-running 0..SAMPLE_PERIOD_CYCLES-1, wraps to 0.
  - A conversion start is requested when the counter is 0.
  - A request arriving while not in IDLE is dropped; the next period is used.
- State machine:
  - IDLE: all strobes inactive. On a start request, go to CONVST.
  - CONVST: conv_start_a..d driven 1 together for CONVST_HIGH_CYCLES cycles, then driven 0 (the ADC starts on the rising edge). Then go to WAIT_BUSY_HI.
  - WAIT_BUSY_HI:
    - busy=1 → WAIT_BUSY_LO.
    - busy still 0 after BUSY_TIMEOUT_CYCLES → IDLE, with no reads and no data_valid.
  - WAIT_BUSY_LO: wait for busy=0 (no timeout). Next cycle go to READ_LOW with chipselect_n=0 and word counter=0.
  - READ_LOW:
    - read_n=0 and chipselect_n=0 for RD_LOW_CYCLES cycles.
    - On the final low cycle, capture data_adc into data_out and pulse data_valid for exactly that one cycle.
    - read_n rises on the next cycle.
  - READ_HIGH:
    - read_n=1, chipselect_n stays 0, for RD_HIGH_CYCLES cycles; increment word counter.
    - If word counter < NUM_CHANNELS, return to READ_LOW.
    - Otherwise set chipselect_n=1 and go to IDLE.
- Each conversion yields exactly NUM_CHANNELS data_valid pulses, in ADC channel order. data_out holds its value between strobes.
- busy changing during the read phase is ignored.
- Output constancy: write_n, software_mode, serial_mode and standby_n never toggle.

Test Plan:
- Reset: assert rst for 2 cycles mid-read, with chipselect_n=0 and read_n=0 at the time → all outputs return to reset values asynchronously, and no data_valid occurs until the next full conversion.
- Normal cycle: ADC model raises busy 3 cycles after CONVST and holds it 20 cycles, with data_adc returning 0x1111·(n+1) for word n → conv_start_a..d high for exactly 2 cycles, then exactly 8 data_valid pulses with data_out = 0x1111 … 0x8888, then chipselect_n=1.
- Read timing: check each read_n low pulse is 2 cycles and each high gap is 1 cycle. Check chipselect_n is low continuously across all 8 words. Check data_valid coincides with the second low cycle.
- Periodicity: run 5 conversions → rising edges of conv_start_a are exactly 64 cycles apart, and all four conv_start lines are identical.
- Busy timeout: hold busy=0 → after 16 cycles return to IDLE with no read_n activity. The next period starts normally.
- Static pins: over the whole run, write_n=1, software_mode=0, serial_mode=0 and standby_n=1 at all times.

Source files
------------

// File: rtl/adc_parallel_driver.sv
// Hardware-mode parallel-bus sequencer for an AD7606-class simultaneous-sampling ADC:
// periodic CONVST, BUSY handshake, then a CS_N/RD_N burst streaming words out as strobes.
module adc_parallel_driver #(
  parameter int NUM_CHANNELS         = 8,
  parameter int SAMPLE_PERIOD_CYCLES = 64,
  parameter int CONVST_HIGH_CYCLES   = 2,
  parameter int RD_LOW_CYCLES        = 2,
  parameter int RD_HIGH_CYCLES       = 1,
  parameter int BUSY_TIMEOUT_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busy,
  input  logic [15:0] data_adc,
  output logic        read_n,
  output logic        write_n,
  output logic        chipselect_n,
  output logic        software_mode,
  output logic        serial_mode,
  output logic        standby_n,
  output logic        conv_start_a,
  output logic        conv_start_b,
  output logic        conv_start_c,
  output logic        conv_start_d,
  output logic [15:0] data_out,
  output logic        data_valid
);

  localparam int PW     = $clog2(SAMPLE_PERIOD_CYCLES);
  localparam int MAX_A  = (CONVST_HIGH_CYCLES > BUSY_TIMEOUT_CYCLES) ? CONVST_HIGH_CYCLES
                                                                      : BUSY_TIMEOUT_CYCLES;
  localparam int MAX_B  = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int CNT_W  = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);
  localparam int WW     = $clog2(NUM_CHANNELS + 1);

  // state     | meaning
  // IDLE      | strobes inactive, waiting for period counter wrap
  // CONVST    | CONVST A..D high together
  // WAIT_HI   | waiting for BUSY to rise, bounded by timeout
  // WAIT_LO   | conversion running, waiting for BUSY to fall
  // READ_LO   | CS_N and RD_N low for one word
  // READ_HI   | RD_N high gap, CS_N still low
  typedef enum logic [2:0] {
    S_IDLE, S_CONVST, S_WAIT_HI, S_WAIT_LO, S_READ_LO, S_READ_HI
  } state_t;

  state_t             state_q;
  logic [PW-1:0]      period_q, period_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WW-1:0]      word_q;
  logic               conv_q, read_n_q, cs_n_q, valid_q;
  logic [15:0]        data_q;
  logic               start_req;

  always_comb begin
    period_d = period_q + PW'(1);
    if (period_q == PW'(SAMPLE_PERIOD_CYCLES - 1)) period_d = '0;
  end

  assign start_req = (period_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_q <= '0;
    else     period_q <= period_d;
  end

  // Capture fires on the edge entering the last low cycle; assumes RD_LOW_CYCLES >= 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      conv_q   <= 1'b0;
      read_n_q <= 1'b1;
      cs_n_q   <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            state_q <= S_CONVST;
            conv_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_CONVST: begin
          if (cnt_q == CNT_W'(CONVST_HIGH_CYCLES - 1)) begin
            conv_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT_HI;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_HI: begin
          if (busy) begin
            state_q <= S_WAIT_LO;
          end else if (cnt_q == CNT_W'(BUSY_TIMEOUT_CYCLES - 1)) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LO: begin
          if (!busy) begin
            state_q  <= S_READ_LO;
            cs_n_q   <= 1'b0;
            read_n_q <= 1'b0;
            word_q   <= '0;
            cnt_q    <= '0;
          end
        end
        S_READ_LO: begin
          if (cnt_q == CNT_W'(RD_LOW_CYCLES - 2)) begin
            data_q  <= data_adc;
            valid_q <= 1'b1;
          end
          if (cnt_q == CNT_W'(RD_LOW_CYCLES - 1)) begin
            read_n_q <= 1'b1;
            cnt_q    <= '0;
            word_q   <= word_q + WW'(1);
            state_q  <= S_READ_HI;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_READ_HI: begin
          if (cnt_q == CNT_W'(RD_HIGH_CYCLES - 1)) begin
            cnt_q <= '0;
            if (word_q < WW'(NUM_CHANNELS)) begin
              read_n_q <= 1'b0;
              state_q  <= S_READ_LO;
            end else begin
              cs_n_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign conv_start_a  = conv_q;
  assign conv_start_b  = conv_q;
  assign conv_start_c  = conv_q;
  assign conv_start_d  = conv_q;
  assign read_n        = read_n_q;
  assign chipselect_n  = cs_n_q;
  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign write_n       = 1'b1;
  assign software_mode = 1'b0;
  assign serial_mode   = 1'b0;
  assign standby_n     = 1'b1;

endmodule

// File: tb/tb_adc_parallel_driver.sv
// Bench for adc_parallel_driver: behavioural ADC pin model plus trace-based checks of
// conversion periodicity, BUSY handshake, read burst timing, data ordering and reset abort.
module tb_adc_parallel_driver;

  logic        clk, rst, busy;
  logic [15:0] data_adc;
  logic        read_n, write_n, chipselect_n, software_mode, serial_mode, standby_n;
  logic        conv_start_a, conv_start_b, conv_start_c, conv_start_d;
  logic [15:0] data_out;
  logic        data_valid;

  adc_parallel_driver dut (
    .clk(clk), .rst(rst), .busy(busy), .data_adc(data_adc),
    .read_n(read_n), .write_n(write_n), .chipselect_n(chipselect_n),
    .software_mode(software_mode), .serial_mode(serial_mode), .standby_n(standby_n),
    .conv_start_a(conv_start_a), .conv_start_b(conv_start_b),
    .conv_start_c(conv_start_c), .conv_start_d(conv_start_d),
    .data_out(data_out), .data_valid(data_valid)
  );

  localparam int PERIOD = 64;
  localparam int NWORDS = 8;

  typedef struct {
    logic [3:0]  conv;
    logic        rd;
    logic        cs;
    logic        vld;
    logic [15:0] dout;
  } smp_t;

  smp_t        tr[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          static_bad = 0;
  logic [15:0] cfg_word [8][8];
  int          cfg_hold [8];
  bit          cfg_to   [8];
  bit          cfg_noise[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic smp_t take();
    smp_t s;
    s.conv = {conv_start_d, conv_start_c, conv_start_b, conv_start_a};
    s.rd   = read_n;
    s.cs   = chipselect_n;
    s.vld  = data_valid;
    s.dout = data_out;
    return s;
  endfunction

  // Static pins must hold in every cycle, reset included
  always @(negedge clk)
    if (write_n !== 1'b1 || software_mode !== 1'b0 || serial_mode !== 1'b0 || standby_n !== 1'b1)
      static_bad++;

  // ADC pin model: BUSY rises 3 cycles after CONVST, stays high cfg_hold cycles;
  // each RD_N falling edge presents the next channel word.
  initial begin : adc_model
    int conv_idx, rd_idx, busy_wait, busy_left;
    logic conv_prev, rd_prev;
    conv_idx = -1; rd_idx = -1; busy_wait = 0; busy_left = 0;
    conv_prev = 1'b0; rd_prev = 1'b1;
    busy = 1'b0; data_adc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0; busy_wait = 0; busy_left = 0;
        conv_prev = 1'b0; rd_prev = 1'b1; data_adc = '0;
      end else begin
        if (conv_start_a && !conv_prev) begin
          if (conv_idx < 7) conv_idx++;
          rd_idx    = -1;
          busy_left = 0;
          busy_wait = cfg_to[conv_idx] ? 0 : 3;
        end else if (busy_wait > 0) begin
          busy_wait--;
          if (busy_wait == 0) begin
            busy      = 1'b1;
            busy_left = cfg_hold[conv_idx];
          end
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) busy = 1'b0;
        end else if (!chipselect_n && conv_idx >= 0 && cfg_noise[conv_idx]) begin
          busy = 1'($urandom_range(0, 1));
        end else begin
          busy = 1'b0;
        end
        if (!read_n && rd_prev) begin
          rd_idx++;
          if (rd_idx < NWORDS && conv_idx >= 0) data_adc = cfg_word[conv_idx][rd_idx];
        end
        conv_prev = conv_start_a;
        rd_prev   = read_n;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ctl"},
          {21'd0, read_n, chipselect_n, write_n, conv_start_a, conv_start_b, conv_start_c,
           conv_start_d, data_valid, software_mode, serial_mode, standby_n},
          {21'd0, 11'b111_0000_0_001});
    check({tag, "_dout"}, {16'd0, data_out}, 32'd0);
  endtask

  task automatic wait_rise(input string tag);
    bit found = 0;
    int pre_vld = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (conv_start_a === 1'b1) begin
        found = 1;
        break;
      end
      if (data_valid === 1'b1) pre_vld++;
    end
    check({tag, "_found"}, {31'd0, found}, 32'd1);
    check({tag, "_vld_before"}, pre_vld, 0);
  endtask

  task automatic record(input int n);
    tr.delete();
    tr.push_back(take());
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      tr.push_back(take());
    end
  endtask

  // Expected behaviour of one 64-cycle window that begins on a CONVST rising edge
  task automatic analyze(input int base, input int ci);
    int conv_hi = 0, conv_split = 0, runs = 0, bad_len = 0, bad_gap = 0, first_lo = -1;
    int vld = 0, bad_vld = 0, cs_lo = 0, cs_runs = 0, bad_hold = 0, run_len = 0, last_end = -1;
    string p;
    p = $sformatf("c%0d", ci);
    if (base > 0) check({p, "_rise"}, {24'd0, tr[base-1].conv, tr[base].conv}, 32'h0F);
    else          check({p, "_rise"}, {28'd0, tr[base].conv}, 32'hF);
    check({p, "_conv_2nd"}, {28'd0, tr[base+1].conv}, 32'hF);
    for (int i = base; i < base + PERIOD; i++) begin
      if (tr[i].conv[0]) conv_hi++;
      if (tr[i].conv != 4'h0 && tr[i].conv != 4'hF) conv_split++;
      if (!tr[i].rd) begin
        run_len++;
        if (run_len == 1) begin
          runs++;
          if (first_lo < 0) first_lo = i - base;
          if (last_end >= 0 && (i - last_end - 1) != 1) bad_gap++;
        end
      end else if (run_len > 0) begin
        if (run_len != 2) bad_len++;
        last_end = i - 1;
        run_len  = 0;
      end
      if (!tr[i].cs) begin
        cs_lo++;
        if (i == base || tr[i-1].cs) cs_runs++;
      end
      if (tr[i].vld) begin
        if (i < 2 || tr[i].rd || tr[i-1].rd || !tr[i-2].rd) bad_vld++;
        if (vld < NWORDS)
          check($sformatf("%s_data%0d", p, vld), {16'd0, tr[i].dout}, {16'd0, cfg_word[ci][vld]});
        vld++;
      end else if (i > base && tr[i].dout !== tr[i-1].dout) begin
        bad_hold++;
      end
    end
    if (run_len > 0) bad_len++;
    check({p, "_conv_hi"}, conv_hi, 2);
    check({p, "_conv_split"}, conv_split, 0);
    check({p, "_hold"}, bad_hold, 0);
    check({p, "_cs_end"}, {31'd0, tr[base+PERIOD-1].cs}, 32'd1);
    if (cfg_to[ci]) begin
      check({p, "_to_rd"}, runs, 0);
      check({p, "_to_vld"}, vld, 0);
      check({p, "_to_cs"}, cs_lo, 0);
    end else begin
      check({p, "_runs"}, runs, NWORDS);
      check({p, "_rd_len"}, bad_len, 0);
      check({p, "_rd_gap"}, bad_gap, 0);
      check({p, "_rd_start"}, first_lo, 4 + cfg_hold[ci]);
      check({p, "_vld_cnt"}, vld, NWORDS);
      check({p, "_vld_pos"}, bad_vld, 0);
      check({p, "_cs_len"}, cs_lo, NWORDS * 3);
      check({p, "_cs_runs"}, cs_runs, 1);
    end
  endtask

  initial begin : main
    bit found;
    for (int c = 0; c < 8; c++) begin
      cfg_hold[c]  = $urandom_range(5, 25);
      cfg_to[c]    = 1'b0;
      cfg_noise[c] = 1'b0;
      for (int w = 0; w < NWORDS; w++) cfg_word[c][w] = 16'($urandom);
    end
    cfg_hold[0] = 20;
    for (int w = 0; w < NWORDS; w++) cfg_word[0][w] = 16'(16'h1111 * (w + 1));
    cfg_to[2]    = 1'b1;
    cfg_noise[3] = 1'b1;
    cfg_noise[4] = 1'b1;

    rst = 1'b1;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por_clk");
    rst = 1'b0;

    wait_rise("rise0");
    record(5 * PERIOD);
    for (int w = 0; w < 5; w++) analyze(w * PERIOD, w);

    // Abort conversion 5 in the middle of its read burst
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (read_n === 1'b0 && chipselect_n === 1'b0) begin
        found = 1;
        break;
      end
    end
    check("midread_found", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst_mid_hold");
    rst = 1'b0;

    wait_rise("rise_post");
    record(PERIOD);
    analyze(0, 6);

    check("static_pins", static_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
